// File: rtl/reconstruction_adder.sv
// ---------------------------------------------------------------------------
// reconstruction_adder
//
// Reads the 384 prediction bytes of one macroblock from the completed-
// prediction buffer in block order. Adds the signed IDCT residual to each
// byte and saturates the sum to 0..255. Streams the reconstructed pixels,
// with block/index sideband, to the frame-store writer.
//
// Ports
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   Start_I                 one-cycle pulse starting a macroblock (IDLE only)
//   Slot_I, Intra_I,        macroblock slot, intra flag and coded block
//   Coded_Block_Pattern_I   pattern; all are captured with Start_I
//   Busy_O, Done_O          macroblock in progress / completion pulse
//   Buf_Address_O           prediction buffer byte address (fetch cycle)
//   Buf_Data_I              prediction byte, one cycle after its address
//   Residual_Valid_I/_I     residual stream; Residual_Ready_O consumes
//   Pixel_Valid_O/Ready_I   output handshake for Pixel_O, Pixel_Block_O,
//                           Pixel_Index_O
// ---------------------------------------------------------------------------
module reconstruction_adder #(
    parameter int unsigned SLOT_STRIDE = 512
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        Start_I,
    input  logic [1:0]  Slot_I,
    input  logic        Intra_I,
    input  logic [5:0]  Coded_Block_Pattern_I,
    output logic        Busy_O,
    output logic        Done_O,
    output logic [10:0] Buf_Address_O,
    input  logic [7:0]  Buf_Data_I,
    input  logic        Residual_Valid_I,
    input  logic [8:0]  Residual_I,
    output logic        Residual_Ready_O,
    output logic        Pixel_Valid_O,
    input  logic        Pixel_Ready_I,
    output logic [7:0]  Pixel_O,
    output logic [2:0]  Pixel_Block_O,
    output logic [5:0]  Pixel_Index_O
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Control state
    state_t     state_q, state_d;
    logic [1:0] slot_q, slot_d;
    logic       intra_q, intra_d;
    logic [5:0] cbp_q, cbp_d;
    logic [2:0] blk_q, blk_d;
    logic [5:0] idx_q, idx_d;

    // Fetch issued last cycle, waiting for its buffer byte
    logic       infl_valid_q, infl_valid_d;
    logic [8:0] infl_res_q, infl_res_d;
    logic [2:0] infl_blk_q, infl_blk_d;
    logic [5:0] infl_idx_q, infl_idx_d;

    // Two-entry output FIFO
    logic [7:0] fifo_pix_q [2];
    logic [7:0] fifo_pix_d [2];
    logic [2:0] fifo_blk_q [2];
    logic [2:0] fifo_blk_d [2];
    logic [5:0] fifo_idx_q [2];
    logic [5:0] fifo_idx_d [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;

    // Combinational helpers
    logic        blk_coded;
    logic [1:0]  credit;
    logic        pop;
    logic        room;
    logic        fetch;
    logic        last_fetch;
    logic        drain_done;
    logic [10:0] base;
    logic [10:0] offset;
    logic [7:0]  pred;
    logic [9:0]  sum;
    logic [7:0]  pix_sat;

    // -----------------------------------------------------------------------
    // Fetch control
    // -----------------------------------------------------------------------
    always_comb begin : fetch_ctrl
        blk_coded = 1'b0;
        case (blk_q)
            3'd0:    blk_coded = cbp_q[5];
            3'd1:    blk_coded = cbp_q[4];
            3'd2:    blk_coded = cbp_q[3];
            3'd3:    blk_coded = cbp_q[2];
            3'd4:    blk_coded = cbp_q[1];
            3'd5:    blk_coded = cbp_q[0];
            default: blk_coded = 1'b0;
        endcase

        // Credit = FIFO occupancy + read in flight; never exceeds 2.
        credit = count_q + {1'b0, infl_valid_q};
        pop    = (count_q != 2'd0) && Pixel_Ready_I;
        // A pop in the same cycle frees a slot for this fetch, so credit is
        // unchanged and Ready held high sustains one pixel per cycle.
        room   = (credit < 2'd2) || pop;

        fetch      = (state_q == ST_RUN) && room && (!blk_coded || Residual_Valid_I);
        last_fetch = fetch && (blk_q == 3'd5) && (idx_q == 6'd63);
        drain_done = (state_q == ST_DRAIN) && (count_q == 2'd0) && !infl_valid_q;
    end

    // -----------------------------------------------------------------------
    // Buffer address: luma blocks 0..3 tile a 16x16 area with a 16-byte row
    // pitch; chroma blocks 4 and 5 are stored linearly after it.
    // -----------------------------------------------------------------------
    always_comb begin : addr_gen
        base = 11'(32'(slot_q) * SLOT_STRIDE);
        case (blk_q)
            3'd4:    offset = 11'd256 + {5'd0, idx_q};
            3'd5:    offset = 11'd320 + {5'd0, idx_q};
            // (blk[1]*8 + row)*16 + blk[0]*8 + col, as bit fields
            default: offset = {3'd0, blk_q[1], idx_q[5:3], blk_q[0], idx_q[2:0]};
        endcase
        Buf_Address_O = base + offset;
    end

    // -----------------------------------------------------------------------
    // Reconstruction: 10-bit two's-complement sum, range -256..510.
    // Bit 9 set means negative; bit 8 set (when non-negative) means >255.
    // -----------------------------------------------------------------------
    always_comb begin : recon
        pred = intra_q ? 8'd0 : Buf_Data_I;
        sum  = {2'b00, pred} + {infl_res_q[8], infl_res_q};
        if (sum[9]) begin
            pix_sat = 8'd0;
        end else if (sum[8]) begin
            pix_sat = 8'hFF;
        end else begin
            pix_sat = sum[7:0];
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin : next_state
        state_d      = state_q;
        slot_d       = slot_q;
        intra_d      = intra_q;
        cbp_d        = cbp_q;
        blk_d        = blk_q;
        idx_d        = idx_q;
        infl_valid_d = fetch;
        infl_res_d   = infl_res_q;
        infl_blk_d   = infl_blk_q;
        infl_idx_d   = infl_idx_q;
        fifo_pix_d   = fifo_pix_q;
        fifo_blk_d   = fifo_blk_q;
        fifo_idx_d   = fifo_idx_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q + {1'b0, infl_valid_q} - {1'b0, pop};

        case (state_q)
            ST_IDLE: begin
                if (Start_I) begin
                    state_d = ST_RUN;
                    slot_d  = Slot_I;
                    intra_d = Intra_I;
                    cbp_d   = Intra_I ? 6'h3F : Coded_Block_Pattern_I;
                    blk_d   = '0;
                    idx_d   = '0;
                end
            end
            ST_RUN: begin
                if (last_fetch) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (fetch) begin
            // Uncoded blocks consume no residual and add zero.
            infl_res_d = blk_coded ? Residual_I : '0;
            infl_blk_d = blk_q;
            infl_idx_d = idx_q;
            if (idx_q == 6'd63) begin
                idx_d = '0;
                blk_d = (blk_q == 3'd5) ? 3'd0 : blk_q + 3'd1;
            end else begin
                idx_d = idx_q + 6'd1;
            end
        end

        if (infl_valid_q) begin
            fifo_pix_d[wr_ptr_q] = pix_sat;
            fifo_blk_d[wr_ptr_q] = infl_blk_q;
            fifo_idx_d[wr_ptr_q] = infl_idx_q;
            wr_ptr_d             = ~wr_ptr_q;
        end

        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            slot_q       <= '0;
            intra_q      <= 1'b0;
            cbp_q        <= '0;
            blk_q        <= '0;
            idx_q        <= '0;
            infl_valid_q <= 1'b0;
            infl_res_q   <= '0;
            infl_blk_q   <= '0;
            infl_idx_q   <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_pix_q[i] <= '0;
                fifo_blk_q[i] <= '0;
                fifo_idx_q[i] <= '0;
            end
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            intra_q      <= intra_d;
            cbp_q        <= cbp_d;
            blk_q        <= blk_d;
            idx_q        <= idx_d;
            infl_valid_q <= infl_valid_d;
            infl_res_q   <= infl_res_d;
            infl_blk_q   <= infl_blk_d;
            infl_idx_q   <= infl_idx_d;
            fifo_pix_q   <= fifo_pix_d;
            fifo_blk_q   <= fifo_blk_d;
            fifo_idx_q   <= fifo_idx_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign Busy_O           = (state_q != ST_IDLE);
    assign Done_O           = drain_done;
    assign Residual_Ready_O = (state_q == ST_RUN) && blk_coded && room;
    assign Pixel_Valid_O    = (count_q != 2'd0);
    assign Pixel_O          = fifo_pix_q[rd_ptr_q];
    assign Pixel_Block_O    = fifo_blk_q[rd_ptr_q];
    assign Pixel_Index_O    = fifo_idx_q[rd_ptr_q];

endmodule

// File: tb/tb_reconstruction_adder.sv
module tb_reconstruction_adder;

    localparam int MAX_CYC = 4000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        Start_I = 1'b0;
    logic [1:0]  Slot_I = '0;
    logic        Intra_I = 1'b0;
    logic [5:0]  Coded_Block_Pattern_I = '0;
    logic        Busy_O;
    logic        Done_O;
    logic [10:0] Buf_Address_O;
    logic [7:0]  Buf_Data_I = '0;
    logic        Residual_Valid_I = 1'b0;
    logic [8:0]  Residual_I = '0;
    logic        Residual_Ready_O;
    logic        Pixel_Valid_O;
    logic        Pixel_Ready_I = 1'b0;
    logic [7:0]  Pixel_O;
    logic [2:0]  Pixel_Block_O;
    logic [5:0]  Pixel_Index_O;

    always #5 clock = ~clock;

    reconstruction_adder #(.SLOT_STRIDE(512)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .Start_I               (Start_I),
        .Slot_I                (Slot_I),
        .Intra_I               (Intra_I),
        .Coded_Block_Pattern_I (Coded_Block_Pattern_I),
        .Busy_O                (Busy_O),
        .Done_O                (Done_O),
        .Buf_Address_O         (Buf_Address_O),
        .Buf_Data_I            (Buf_Data_I),
        .Residual_Valid_I      (Residual_Valid_I),
        .Residual_I            (Residual_I),
        .Residual_Ready_O      (Residual_Ready_O),
        .Pixel_Valid_O         (Pixel_Valid_O),
        .Pixel_Ready_I         (Pixel_Ready_I),
        .Pixel_O               (Pixel_O),
        .Pixel_Block_O         (Pixel_Block_O),
        .Pixel_Index_O         (Pixel_Index_O)
    );

    typedef struct {
        int pred;
        int res;
        int expv;
    } sat_vec_t;

    sat_vec_t    sat_tab [10];

    int          total = 0;
    int          bad = 0;

    logic [7:0]  mem [0:2047];
    int          res_arr [0:511];
    int          exp_val [0:383];
    int          pix_log [0:383];
    logic [10:0] addr_log [0:MAX_CYC-1];
    logic        busy_log [0:MAX_CYC-1];
    logic [10:0] addr_prev = '0;
    int          pix_cnt, res_cnt, n_coded, rr_extra, max_out;
    int          done_cycle, first_valid;

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s got=0x%0h want=0x%0h", name, act, expv);
        end
    endtask

    function automatic int model_addr(input int slot, input int blk, input int idx);
        int a;
        int r;
        int c;
        r = idx / 8;
        c = idx % 8;
        if (blk < 4)
            a = slot * 512 + ((blk / 2) * 8 + r) * 16 + (blk % 2) * 8 + c;
        else if (blk == 4)
            a = slot * 512 + 256 + idx;
        else
            a = slot * 512 + 320 + idx;
        return a % 2048;
    endfunction

    function automatic int clamp8(input int v);
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    // Runs one macroblock from a negedge; checks every pixel against the model.
    task automatic run_mb(input int slot, input bit intra, input logic [5:0] cbp,
                          input bit rnd, input int abort_pix, input int stray_cyc);
        int  k;
        int  ri;
        int  cur_out;
        int  prev_out;
        bit  prev_stall;
        bit  done_seen;
        bit  aborted;
        bit  coded;
        int  pred;
        int  r;
        k = 0;
        for (int b = 0; b < 6; b++) begin
            coded = intra || cbp[5 - b];
            for (int i = 0; i < 64; i++) begin
                pred = intra ? 0 : int'(mem[model_addr(slot, b, i)]);
                r    = 0;
                if (coded) begin
                    r = res_arr[k];
                    k++;
                end
                exp_val[b * 64 + i] = (clamp8(pred + r) << 9) | (b << 6) | i;
            end
        end
        n_coded     = k;
        ri          = 0;
        pix_cnt     = 0;
        res_cnt     = 0;
        rr_extra    = 0;
        max_out     = 0;
        done_cycle  = -1;
        first_valid = -1;
        prev_stall  = 1'b0;
        prev_out    = 0;
        done_seen   = 1'b0;
        aborted     = 1'b0;
        for (int cyc = 0; cyc < MAX_CYC; cyc++) begin
            Start_I               = (cyc == 0) || (cyc == stray_cyc);
            Slot_I                = (cyc == 0) ? 2'(slot) : 2'(slot + 1);
            Intra_I               = (cyc == 0) ? intra : !intra;
            Coded_Block_Pattern_I = (cyc == 0) ? cbp : ~cbp;
            Buf_Data_I            = mem[addr_prev];
            Pixel_Ready_I         = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            Residual_Valid_I      = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            Residual_I            = (ri < 512) ? 9'(res_arr[ri]) : 9'd0;
            #1;
            addr_prev      = Buf_Address_O;
            addr_log[cyc]  = Buf_Address_O;
            busy_log[cyc]  = Busy_O;
            cur_out = int'({Pixel_Valid_O, Pixel_O, Pixel_Block_O, Pixel_Index_O});
            if (prev_stall) chk("stall_hold", cur_out, prev_out);
            if (Pixel_Valid_O && first_valid < 0) first_valid = cyc;
            if (Pixel_Valid_O && Pixel_Ready_I) begin
                if (pix_cnt < 384) begin
                    chk($sformatf("pixel[%0d]", pix_cnt),
                        int'({Pixel_O, Pixel_Block_O, Pixel_Index_O}), exp_val[pix_cnt]);
                    pix_log[pix_cnt] = int'(Pixel_O);
                end
                pix_cnt++;
            end
            if (Residual_Ready_O && res_cnt >= n_coded) rr_extra++;
            if (Residual_Valid_I && Residual_Ready_O) begin
                ri++;
                res_cnt++;
            end
            if (res_cnt - pix_cnt > max_out) max_out = res_cnt - pix_cnt;
            prev_stall = Pixel_Valid_O && !Pixel_Ready_I;
            prev_out   = cur_out;
            if (Done_O) begin
                done_cycle = cyc;
                done_seen  = 1'b1;
            end
            @(negedge clock);
            if (done_seen) break;
            if (abort_pix > 0 && pix_cnt >= abort_pix) begin
                aborted = 1'b1;
                break;
            end
        end
        Start_I = 1'b0;
        if (!aborted) begin
            chk("done_seen", int'(done_seen), 1);
            chk("pix_count", pix_cnt, 384);
            chk("res_count", res_cnt, n_coded);
            chk("rr_after_coded", rr_extra, 0);
            if (intra || cbp == 6'h3F) chk("credit_le_2", int'(max_out <= 2), 1);
            #1;
            chk("done_one_pulse", int'(Done_O), 0);
            chk("busy_after_done", int'(Busy_O), 0);
            @(negedge clock);
        end
    endtask

    task automatic fill_random();
        for (int a = 0; a < 2048; a++) mem[a] = 8'($urandom);
        for (int i = 0; i < 512; i++) res_arr[i] = int'($urandom_range(0, 511)) - 256;
    endtask

    initial begin
        sat_tab[0] = '{250,   10, 255};
        sat_tab[1] = '{  5,  -20,   0};
        sat_tab[2] = '{100, -256,   0};
        sat_tab[3] = '{  0,  255, 255};
        sat_tab[4] = '{128,   -1, 127};
        sat_tab[5] = '{200,   55, 255};
        sat_tab[6] = '{200,   54, 254};
        sat_tab[7] = '{255, -256,   0};
        sat_tab[8] = '{ 77,   23, 100};
        sat_tab[9] = '{  1,   -1,   0};

        // Reset values
        repeat (3) @(negedge clock);
        #1;
        chk("reset_outputs",
            int'({Busy_O, Done_O, Buf_Address_O, Residual_Ready_O, Pixel_Valid_O,
                  Pixel_O, Pixel_Block_O, Pixel_Index_O}), 0);
        reset = 1'b0;
        @(negedge clock);

        // Addressing and timing: byte = low 8 address bits, zero residual
        for (int a = 0; a < 2048; a++) mem[a] = 8'(a);
        for (int i = 0; i < 512; i++) res_arr[i] = 0;
        run_mb(1, 1'b0, 6'h3F, 1'b0, 0, -1);
        chk("t1_pix0", pix_log[0], 0);
        chk("t1_addr_b0i0", int'(addr_log[1]), 512);
        chk("t1_addr_b1i0", int'(addr_log[65]), 520);
        chk("t1_addr_b4i0", int'(addr_log[257]), 768);
        chk("t1_addr_b5i0", int'(addr_log[321]), 832);
        chk("t1_pix64", pix_log[64], 8);
        chk("t1_done_cycle", done_cycle, 387);
        chk("t1_first_valid", first_valid, 3);
        chk("t1_busy_c0", int'(busy_log[0]), 0);
        chk("t1_busy_c1", int'(busy_log[1]), 1);

        // Saturation table in block 0 of slot 0
        for (int a = 0; a < 2048; a++) mem[a] = 8'd0;
        for (int i = 0; i < 512; i++) res_arr[i] = 0;
        for (int i = 0; i < 10; i++) begin
            mem[model_addr(0, 0, i)] = 8'(sat_tab[i].pred);
            res_arr[i] = sat_tab[i].res;
        end
        run_mb(0, 1'b0, 6'h3F, 1'b0, 0, -1);
        for (int i = 0; i < 10; i++) chk($sformatf("sat[%0d]", i), pix_log[i], sat_tab[i].expv);

        // Only block 0 coded
        fill_random();
        run_mb(2, 1'b0, 6'b100000, 1'b0, 0, -1);
        chk("t3_res_count", res_cnt, 64);
        chk("t3_raw_b1i0", pix_log[64], int'(mem[model_addr(2, 1, 0)]));

        // Intra with CBP input 0: prediction ignored, all residuals used
        fill_random();
        run_mb(3, 1'b1, 6'b000000, 1'b0, 0, -1);
        chk("t4_res_count", res_cnt, 384);
        chk("t4_pix0", pix_log[0], clamp8(res_arr[0]));

        // Random stalls and residual gaps, with a stray Start_I while busy
        fill_random();
        run_mb(0, 1'b0, 6'h3F, 1'b1, 0, 50);
        fill_random();
        run_mb(1, 1'b0, 6'b101101, 1'b1, 0, 120);

        // Reset in block 2, then a fresh macroblock
        fill_random();
        run_mb(2, 1'b0, 6'h3F, 1'b0, 140, -1);
        reset = 1'b1;
        #1;
        chk("midreset_outputs",
            int'({Busy_O, Done_O, Buf_Address_O, Residual_Ready_O, Pixel_Valid_O,
                  Pixel_O, Pixel_Block_O, Pixel_Index_O}), 0);
        @(negedge clock);
        #1;
        chk("midreset_hold",
            int'({Busy_O, Done_O, Buf_Address_O, Residual_Ready_O, Pixel_Valid_O,
                  Pixel_O, Pixel_Block_O, Pixel_Index_O}), 0);
        reset = 1'b0;
        @(negedge clock);
        run_mb(1, 1'b0, 6'b010101, 1'b1, 0, -1);
        chk("restart_addr", int'(addr_log[1]), model_addr(1, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
